m_extension_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes the decoded control word's m_extension_act request together with funct3 and the forwarded rs1/rs2 values.
- Returns a 32-bit result through a start/done handshake; busy drives the pipeline stall logic.
- One operation in flight at a time; operands are latched at acceptance.

---
 rtl/m_extension_unit.sv | 169 ++++++++++++++++
 tb/tb_m_extension_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/m_extension_unit.sv
// Iterative RV32M multiply/divide unit (EX stage), one operation in flight; M_FAST_MUL_EN makes multiplies single-step.
// Latency: 33 cycles to done (1 for div-by-zero/overflow, or fast multiply); start is ignored while busy.
module m_extension_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a_in, mag_b_in, spec_res;
    logic              fast_hit;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
        case (funct3)
            3'b010:                 b_sgn = 1'b0;
            3'b011, 3'b101, 3'b111: begin a_sgn = 1'b0; b_sgn = 1'b0; end
            default: ;
        endcase
    end

    assign a_neg    = a_sgn & rs1_data[XLEN-1];
    assign b_neg    = b_sgn & rs2_data[XLEN-1];
    assign mag_a_in = a_neg ? -rs1_data : rs1_data;
    assign mag_b_in = b_neg ? -rs2_data : rs2_data;

    // Divide corner cases resolve at acceptance and skip the iteration entirely.
    assign div_zero = funct3[2] & (rs2_data == '0);
    assign div_ovf  = funct3[2] & ~funct3[0] & (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_data == '1);
    assign spec_res = div_zero ? (funct3[1] ? rs1_data : '1)
                               : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

`ifdef M_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_prod_s;
    assign fast_prod   = {{XLEN{1'b0}}, mag_a_in} * {{XLEN{1'b0}}, mag_b_in};
    assign fast_prod_s = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
    assign fast_res    = (funct3[1:0] == 2'b00) ? fast_prod_s[XLEN-1:0] : fast_prod_s[2*XLEN-1:XLEN];
    assign fast_hit    = ~funct3[2];
`else
    assign fast_res    = '0;
    assign fast_hit    = 1'b0;
`endif

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] acc_step, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, calc_res;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, mag_b_q};
        if (op_q[2]) begin
            if (div_trial[XLEN])
                acc_step = {acc_q[2*XLEN-2:0], 1'b0};
            else
                acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end

        prod_s = neg_q  ? -acc_step : acc_step;
        quo_s  = neg_q  ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem_s  = rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 calc_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_res = quo_s;
            default:                calc_res = rem_s;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        mag_b_d  = mag_b_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d    = funct3;
                    mag_b_d = mag_b_in;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    acc_d   = {{XLEN{1'b0}}, mag_a_in};
                    cnt_d   = '0;
                    if (div_zero || div_ovf) begin
                        state_d  = DONE;
                        result_d = spec_res;
                    end else if (fast_hit) begin
                        state_d  = DONE;
                        result_d = fast_res;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d  = DONE;
                    result_d = calc_res;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // An aborted operation must never reach the result register.
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            mag_b_q  <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mag_b_q  <= mag_b_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE) & ~flush;
    assign result = result_q;

endmodule

// File: tb/tb_m_extension_unit.sv
// Self-checking bench for m_extension_unit: arithmetic reference model plus directed vectors.
module tb_m_extension_unit;
    localparam int XLEN = 32;
`ifdef M_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    m_extension_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions, in 64-bit integers.
    function automatic logic [31:0] golden(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic        a_s, b_s;
        longint      sa, sb;
        logic [63:0] p;
        a_s = !(f3 == 3'b011 || f3 == 3'b101 || f3 == 3'b111);
        b_s = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b110);
        sa  = a_s ? {{32{a[31]}}, a} : {32'b0, a};
        sb  = b_s ? {{32{b[31]}}, b} : {32'b0, b};
        if (!f3[2]) begin
            p = sa * sb;
            return (f3 == 3'b000) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        p = f3[1] ? (sa % sb) : (sa / sb);
        return p[31:0];
    endfunction

    function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        if (!f3[2]) return MUL_LAT;
        return 33;
    endfunction

    // Model: m_cnt = busy cycles remaining including the current one; done in the last.
    int          m_cnt = 0;
    logic [31:0] m_val = '0;
    logic [31:0] m_res = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0;
            m_res = '0;
        end else if (m_cnt == 0) begin
            if (start && !flush) begin
                m_cnt = latency(funct3, rs1_data, rs2_data);
                m_val = golden(funct3, rs1_data, rs2_data);
                if (m_cnt == 1) m_res = m_val;
            end
        end else if (flush) begin
            m_cnt = 0;
        end else begin
            m_cnt--;
            if (m_cnt == 1) m_res = m_val;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("busy", {31'b0, busy}, {31'b0, m_cnt > 0});
            check("done", {31'b0, done}, {31'b0, (m_cnt == 1) && !flush});
            check("result", result, m_res);
        end
    end

    // Returns the number of further edges until done is seen, -1 if the bound expires.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) n = -1;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string nm);
        int n;
        funct3 = f3; rs1_data = a; rs2_data = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        wait_done(n);
        check({nm, "_lat"}, (n < 0) ? 32'hFFFF_FFFF : 32'(n + 1), 32'(exp_lat));
        check({nm, "_res"}, result, exp_res);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n, ndone;
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
        #2;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul");
        run_op(3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT, "mulh");
        run_op(3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, MUL_LAT, "mulhu");
        run_op(3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, "div");
        run_op(3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33, "rem");
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu");
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 33, "remu");
        run_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div0");
        run_op(3'b110, 32'd5, 32'd0, 32'd5, 1, "rem0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "divovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "removf");

        // start held high with operands churning: one completion, next op taken in cycle 34.
        funct3 = 3'b101; rs1_data = 32'd1000; rs2_data = 32'd7; start = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                check("hold_res", result, 32'd142);
            end
            if (c == 34) begin
                funct3 = 3'b000; rs1_data = 32'd6; rs2_data = 32'd7;
            end else begin
                funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
            end
        end
        check("hold_ndone", 32'(ndone), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_accept", {31'b0, busy}, 32'd1);
        wait_done(n);
        check("hold_lat2", (n < 0) ? 32'hFFFF_FFFF : 32'(n + 1), 32'(MUL_LAT));
        check("hold_res2", result, 32'd42);
        @(posedge clk); #1;

        // flush in cycle 10 of a divu
        funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_res", result, 32'd42);
        repeat (40) @(posedge clk);
        #1;

        // flush and start together in IDLE
        funct3 = 3'b100; rs1_data = 32'd5; rs2_data = 32'd0; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("fs_busy", {31'b0, busy}, 32'd0);
        check("fs_done", {31'b0, done}, 32'd0);
        check("fs_res", result, 32'd42);
        @(posedge clk); #1;

        // asynchronous reset in the middle of an iterative op
        funct3 = 3'b100; rs1_data = 32'hFFFF_FFEC; rs2_data = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_res", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, "mulhsu");

        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
